// File: rtl/sram_read_arbiter_pkg.sv
// Shared types and constants for the SRAM read arbiter.
// Optional build macro: SRAM_READ_ARBITER_FIXED_PRIORITY_EN (used by the top).
package sram_arb_pkg;

    // Largest supported requester count; the tag id is sized for it so one
    // tag type serves every legal REQUESTER_COUNT (2..8).
    localparam int MAX_REQUESTERS       = 8;
    localparam int REQ_ID_WIDTH         = $clog2(MAX_REQUESTERS);
    localparam int DEFAULT_READ_LATENCY = 2;

    // Travels alongside each read slot; valid=0 marks an idle slot.
    typedef struct packed {
        logic                    valid;
        logic [REQ_ID_WIDTH-1:0] id;
    } tag_t;

endpackage

// File: rtl/sram_read_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker: first eligible request at or
// above ptr, wrapping. Masked requests are never picked.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0] eligible;
    int           pos;
    logic         found;

    assign eligible = req & ~mask;

    // Scan N positions starting at ptr; the first eligible one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && eligible[pos[IW-1:0]]) begin
                grant[pos[IW-1:0]] = 1'b1;
                grant_idx          = pos[IW-1:0];
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter for the single sram_bus read port. SPI writes block
// reads for their cycle; each issued read carries a tag so the returned
// word is steered back to its requester with a one-hot rsp_valid.
// Optional build macro: SRAM_READ_ARBITER_FIXED_PRIORITY_EN gives requester 0
// absolute priority; the others rotate only while requester 0 is idle.
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int REQUESTER_COUNT   = 4,
    parameter int ADDRESS_BUS_WIDTH = 14,
    parameter int DATA_WIDTH        = 16,
    parameter int READ_LATENCY      = DEFAULT_READ_LATENCY
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [REQUESTER_COUNT-1:0]                   req_valid,
    input  logic [REQUESTER_COUNT*ADDRESS_BUS_WIDTH-1:0] req_address,
    output logic [REQUESTER_COUNT-1:0]                   req_ready,
    output logic [REQUESTER_COUNT-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                        rsp_data,
    input  logic                                         write_strobe,
    output logic [ADDRESS_BUS_WIDTH-1:0]                 sram_read_address,
    output logic                                         sram_read_strobe,
    input  logic [DATA_WIDTH-1:0]                        sram_read_data
);

    localparam int PTR_W = $clog2(REQUESTER_COUNT);

    logic [PTR_W-1:0]             ptr;
    logic [PTR_W-1:0]             ptr_next;
    logic [REQUESTER_COUNT-1:0]   pick_mask;
    logic [REQUESTER_COUNT-1:0]   pick_grant;
    logic [PTR_W-1:0]             pick_idx;
    logic [REQUESTER_COUNT-1:0]   grant;
    logic [PTR_W-1:0]             grant_idx;
    logic                         ptr_adv;
    logic                         accept;
    logic [ADDRESS_BUS_WIDTH-1:0] issue_addr;

    // Entry 0 lines up with the strobe cycle; entry READ_LATENCY lines up
    // with the cycle in which sram_read_data is valid for that strobe.
    tag_t [READ_LATENCY:0]        tag_pipe;
    tag_t                         tag_out;

`ifdef SRAM_READ_ARBITER_FIXED_PRIORITY_EN
    assign pick_mask = REQUESTER_COUNT'(1);
`else
    assign pick_mask = '0;
`endif

    rr_pick #(.N(REQUESTER_COUNT), .IW(PTR_W)) u_rr_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .mask      (pick_mask),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Final grant: round-robin pick, overridden by requester 0 when it has
    // absolute priority (such grants leave the pointer alone).
    always_comb begin
        grant     = pick_grant;
        grant_idx = pick_idx;
        ptr_adv   = |pick_grant;
`ifdef SRAM_READ_ARBITER_FIXED_PRIORITY_EN
        if (req_valid[0]) begin
            grant     = REQUESTER_COUNT'(1);
            grant_idx = '0;
            ptr_adv   = 1'b0;
        end
`endif
    end

    assign req_ready = (write_strobe || !rst) ? '0 : grant;
    assign accept    = |req_ready;
    assign ptr_next  = (grant_idx == PTR_W'(REQUESTER_COUNT - 1)) ? '0 : grant_idx + 1'b1;
    assign tag_out   = tag_pipe[READ_LATENCY];

    // Select the accepted requester's address slice.
    always_comb begin
        issue_addr = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (req_ready[i]) issue_addr = req_address[i*ADDRESS_BUS_WIDTH +: ADDRESS_BUS_WIDTH];
        end
    end

    // Issue stage: drive the SRAM read port, advance the pointer, push a tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_read_strobe  <= 1'b0;
            sram_read_address <= '0;
            ptr               <= '0;
            tag_pipe          <= '0;
        end else begin
            sram_read_strobe <= accept;
            if (accept) sram_read_address <= issue_addr;
            if (accept && ptr_adv) ptr <= ptr_next;
            tag_pipe[0].valid <= accept;
            tag_pipe[0].id    <= REQ_ID_WIDTH'(grant_idx);
            for (int i = 1; i <= READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Response stage: steer returned data to the tagged requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < REQUESTER_COUNT; i++)
                rsp_valid[i] <= tag_out.valid && (tag_out.id == REQ_ID_WIDTH'(i));
            if (tag_out.valid) rsp_data <= sram_read_data;
        end
    end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Self-checking bench for sram_read_arbiter against a cycle-level reference
// model of the arbitration rules and a response scoreboard.
// Honours SRAM_READ_ARBITER_FIXED_PRIORITY_EN in its model when defined.
module tb_sram_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int RL = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            write_strobe;
    logic [AW-1:0]   sram_read_address;
    logic            sram_read_strobe;
    logic [DW-1:0]   sram_read_data;

    sram_read_arbiter #(
        .REQUESTER_COUNT(N), .ADDRESS_BUS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_address       (req_address),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .write_strobe      (write_strobe),
        .sram_read_address (sram_read_address),
        .sram_read_strobe  (sram_read_strobe),
        .sram_read_data    (sram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM contents (never written by this bench) and its read pipeline.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] sd  [RL];

    always @(posedge clk) begin
        sd[0] <= mem[sram_read_address];
        for (int i = 1; i < RL; i++) sd[i] <= sd[i-1];
    end
    assign sram_read_data = sd[RL-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    int            errors;
    int            checks;
    int            cyc;
    int            mptr;
    logic [DW-1:0] mdata;
    logic [AW-1:0] addr_of [N];
    rsp_t          sbq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pack_addr();
        for (int i = 0; i < N; i++) req_address[i*AW +: AW] = addr_of[i];
    endtask

    // Which requester should be granted this cycle, or -1 for none.
    function automatic int model_pick();
        int idx;
        if (write_strobe || !rst) return -1;
`ifdef SRAM_READ_ARBITER_FIXED_PRIORITY_EN
        if (req_valid[0]) return 0;
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (idx != 0 && req_valid[idx]) return idx;
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (req_valid[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // One clock: check the grant, clock it, then check issue and response.
    task automatic do_cycle();
        int            g;
        logic [N-1:0]  exp_v;
        logic [AW-1:0] ia;
        rsp_t          e;
        pack_addr();
        #1;
        g = model_pick();
        check("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        ia = (g >= 0) ? addr_of[g] : '0;
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
`ifdef SRAM_READ_ARBITER_FIXED_PRIORITY_EN
            if (g != 0) mptr = (g + 1) % N;
`else
            mptr = (g + 1) % N;
`endif
            sbq.push_back('{due: cyc + RL + 1, id: g, data: mem[ia]});
        end
        #1;
        check("sram_read_strobe", 32'(sram_read_strobe), (g >= 0) ? 32'd1 : 32'd0);
        if (g >= 0) check("sram_read_address", 32'(sram_read_address), 32'(ia));
        exp_v = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            exp_v[e.id] = 1'b1;
            mdata = e.data;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        check("rsp_data", 32'(rsp_data), 32'(mdata));
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        sbq.delete();
        mptr  = 0;
        mdata = '0;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_strobe", 32'(sram_read_strobe), 32'd0);
        check("rst_address", 32'(sram_read_address), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; mptr = 0; mdata = '0;
        rst = 1'b0; req_valid = '0; write_strobe = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        for (int i = 0; i < N; i++) addr_of[i] = '0;
        pack_addr();

        // Reset state with random requests pending.
        req_valid = N'($urandom);
        assert_reset();
        do_cycle();
        do_cycle();

        // Release with all valid: round-robin from requester 0.
        rst = 1'b1;
        req_valid = '1;
        addr_of[0] = 14'h010; addr_of[1] = 14'h020; addr_of[2] = 14'h030; addr_of[3] = 14'h040;
        for (int i = 0; i < 12; i++) do_cycle();

        // Writes every third cycle steal a slot each.
        for (int i = 0; i < 12; i++) begin
            write_strobe = (i % 3 == 0);
            do_cycle();
        end
        write_strobe = 1'b0;

        // Lone requester 2 gets back-to-back reads.
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            addr_of[2] = AW'(14'h100 + i);
            do_cycle();
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) do_cycle();

        // Reset right after two issues: their responses must vanish.
        req_valid = '1;
        for (int i = 0; i < N; i++) addr_of[i] = AW'($urandom);
        do_cycle();
        do_cycle();
        assert_reset();
        do_cycle();
        rst = 1'b1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) do_cycle();
        req_valid = '1;
        for (int i = 0; i < 4; i++) do_cycle();
        req_valid = '0;
        for (int i = 0; i < 4; i++) do_cycle();

        // Requesters 0 and 3 contend, then 0 drops.
        req_valid = 4'b1001;
        for (int i = 0; i < 6; i++) do_cycle();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) do_cycle();
        req_valid = '0;
        for (int i = 0; i < 4; i++) do_cycle();

        // Random traffic with random writes and random address slices.
        for (int i = 0; i < 400; i++) begin
            req_valid    = N'($urandom);
            write_strobe = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < N; j++) addr_of[j] = AW'($urandom);
            do_cycle();
        end
        req_valid = '0;
        write_strobe = 1'b0;
        for (int i = 0; i < 5; i++) do_cycle();
        check("responses_outstanding", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
